// File: rtl/dmem_ctrl.sv
// Byte-addressed big-endian data memory with load/store sizing, power-up clear and fault pulses.
// Define DMEM_MISALIGN_TRAP_EN to fault accesses whose address is not a multiple of their size.
module dmem_ctrl #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter int unsigned ADDR_W      = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_we,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_rvalid,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_err,
   output logic              o_busy
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned ROWS  = DEPTH_BYTES / NB;
   localparam int unsigned IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
   localparam int unsigned PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              rvalid_q, rvalid_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [7:0]        mem_q [DEPTH_BYTES];
   logic [NB-1:0]     wr_en;
   logic [IDX_W-1:0]  wr_idx [NB];
   logic [7:0]        wr_byte [NB];

   logic [IDX_W-1:0]  base_idx;
   logic [2:0]        nbytes;
   logic              size_bad;
   logic              misalign;
   logic              fault;
   logic              accept;
   logic [DATA_W-1:0] ld_val;
   logic              unused_addr_c;

   assign unused_addr_c = ^i_addr;

   // Request decode: addresses wrap modulo the storage size.
   always_comb begin
      base_idx = IDX_W'(i_addr);
      nbytes   = 3'd1 << i_size;
      size_bad = (i_size == 2'b11) || (32'(nbytes) > NB);
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign = |(i_addr[1:0] & 2'(nbytes - 3'd1));
`else
      misalign = 1'b0;
`endif
      fault    = size_bad || misalign;
      accept   = i_req_valid && ready_q;
   end

   // Big-endian gather: lowest address lands in the most significant byte, fill pre-seeded with sign.
   always_comb begin
      ld_val = (!i_unsigned && mem_q[base_idx][7]) ? '1 : '0;
      for (int unsigned k = 0; k < NB; k++) begin
         if (k < 32'(nbytes)) begin
            ld_val = (ld_val << 8) | DATA_W'(mem_q[base_idx + IDX_W'(k)]);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      wr_en    = '0;
      for (int unsigned k = 0; k < NB; k++) begin
         wr_idx[k]  = '0;
         wr_byte[k] = '0;
      end

      case (state_q)
         ST_CLEAR: begin
            for (int unsigned k = 0; k < NB; k++) begin
               wr_en[k]  = 1'b1;
               wr_idx[k] = IDX_W'(ptr_q) * IDX_W'(NB) + IDX_W'(k);
            end
            if (ptr_q == PTR_W'(ROWS - 1)) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end else begin
               ptr_d = ptr_q + PTR_W'(1);
            end
         end
         ST_IDLE: begin
            if (accept) begin
               err_d    = fault;
               rvalid_d = !i_we;
               if (!i_we) begin
                  rdata_d = fault ? '0 : ld_val;
               end else if (!fault) begin
                  for (int unsigned k = 0; k < NB; k++) begin
                     if (k < 32'(nbytes)) begin
                        wr_en[k]   = 1'b1;
                        wr_idx[k]  = base_idx + IDX_W'(k);
                        wr_byte[k] = 8'(i_wdata >> (8 * (32'(nbytes) - 1 - k)));
                     end
                  end
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= ST_CLEAR;
         ptr_q    <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b1;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // Storage has no reset of its own; the clear sweep zeroes it after every reset.
   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         for (int unsigned k = 0; k < NB; k++) begin
            if (wr_en[k]) mem_q[wr_idx[k]] <= wr_byte[k];
         end
      end
   end

   assign o_req_ready = ready_q;
   assign o_busy      = busy_q;
   assign o_rvalid    = rvalid_q;
   assign o_err       = err_q;
   assign o_rdata     = rdata_q;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data port width in bits, a multiple of 8 (8, 16 or 32).
REQ-002 SHALL have parameter DEPTH_BYTES, default 1024, storage size in bytes, a power of 2 and ≥ DATA_W/8.
REQ-003 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-004 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_req_valid  input  1  access request.
REQ-007 SHALL have port o_req_ready  output  1  request accepted when i_req_valid && o_req_ready.
REQ-008 SHALL have port i_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port i_size  input  2  00 byte, 01 half (2 B), 10 word (4 B), 11 illegal.
REQ-010 SHALL have port i_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port i_addr  input  ADDR_W  byte address.
REQ-012 SHALL have port i_wdata  input  DATA_W  store data, low-order bytes used.
REQ-013 SHALL have port o_rvalid  output  1  one-cycle pulse, load response.
REQ-014 SHALL have port o_rdata  output  DATA_W  load data, valid with o_rvalid.
REQ-015 SHALL have port o_err  output  1  one-cycle pulse, access fault.
REQ-016 SHALL have port o_busy  output  1  memory-clear in progress.

Function
REQ-017 SHALL use big-endian byte order: byte at the lowest address is the most significant byte of the access.
REQ-018 SHALL implement FSM states CLEAR and IDLE: CLEAR zeroes one DATA_W/8-byte row per cycle for DEPTH_BYTES/(DATA_W/8) cycles, then moves to IDLE.
REQ-019 SHALL drive o_req_ready=0, o_busy=1 in CLEAR and o_req_ready=1, o_busy=0 in IDLE.
REQ-020 SHALL commit a store on the accepting edge; a load or store on the next cycle observes the new data.
REQ-021 SHALL return load data with fixed latency 1: o_rvalid and o_rdata registered, asserted in the cycle after acceptance.
REQ-022 SHALL accept back-to-back requests every cycle in IDLE, with no bubbles.
REQ-023 SHALL extend loads narrower than DATA_W per i_unsigned; access size greater than DATA_W/8 bytes SHALL be treated as illegal.
REQ-024 SHALL write only the accessed bytes on a store; all other bytes remain unchanged.
REQ-025 SHALL reduce addresses modulo DEPTH_BYTES; a multi-byte access crossing the top wraps to address 0.
REQ-026 SHALL, on illegal size, perform no write, pulse o_err one cycle after acceptance, and for loads pulse o_rvalid with o_rdata=0.
REQ-027 SHALL hold o_rdata at its last value when o_rvalid=0.

Reset
REQ-028 SHALL, while i_rst_n=0, force o_rvalid=0, o_err=0, o_rdata=0, o_req_ready=0, o_busy=1 and the clear pointer to 0.
REQ-029 SHALL enter CLEAR on the first edge with i_rst_n=1; reset mid-CLEAR restarts the clear from row 0.
REQ-030 SHALL discard any load in flight when reset is asserted; no o_rvalid follows it.

Configuration
REQ-031 SHALL support macro DMEM_MISALIGN_TRAP_EN.
REQ-032 With it defined: an access whose address is not a multiple of its size SHALL suppress the write, pulse o_err, and for loads return o_rvalid with o_rdata=0.
REQ-033 Without it: misaligned accesses SHALL complete normally per REQ-025 and o_err SHALL pulse only for illegal size.

Verification
REQ-034 Reset, then release -> o_busy=1 for exactly 256 cycles (DATA_W=32, DEPTH_BYTES=1024); then o_req_ready=1 and a word load at 0x0000 returns 0x00000000.
REQ-035 Word store 0x11223344 at 0x0010, then byte load of 0x0011 with i_unsigned=0 -> o_rdata=0x00000022; half load of 0x0012 -> 0x00003344.
REQ-036 Byte store 0x80 at 0x0020, then signed byte load -> 0xFFFFFF80; unsigned byte load -> 0x00000080.
REQ-037 Store followed by a load to the same address on the next cycle -> new data returned one cycle after the load is accepted; no stall.
REQ-038 Word load at 0x0002: with the macro defined -> o_err=1, o_rvalid=1, o_rdata=0; without it -> bytes 0x0002-0x0005 are returned and o_err=0.
REQ-039 i_size=11 store -> o_err pulse and memory unchanged; reset asserted mid-load -> no o_rvalid, and the clear restarts.
